// File: rtl/otter_intr_ctrl_if.sv
// otter_intr_ctrl_if: IRQ lines, CSR/FSM handshake and request outputs of the interrupt controller
// slave : controller side (irq_in, irq_en, mie, int_taken, mret_exec in; intr, irq_id, irq_pending out)
// master: MCU/peripheral side, directions mirrored
interface otter_intr_ctrl_if #(
  parameter int NUM_SRC = 4
);
  localparam int IW = $clog2(NUM_SRC);
  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] irq_en;
  logic               mie;
  logic               int_taken;
  logic               mret_exec;
  logic               intr;
  logic [IW-1:0]      irq_id;
  logic [NUM_SRC-1:0] irq_pending;
  modport slave (
    input  irq_in, irq_en, mie, int_taken, mret_exec,
    output intr, irq_id, irq_pending
  );
  modport master (
    output irq_in, irq_en, mie, int_taken, mret_exec,
    input  intr, irq_id, irq_pending
  );
endinterface

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: synchronizes IRQ lines, latches rising edges and raises one prioritized INTR to the MCU
// i_clk   : system clock, all logic on posedge
// i_rst_n : synchronous reset, active-low
// bus     : slave modport; irq_in/irq_en/mie/int_taken/mret_exec in, intr/irq_id/irq_pending out
module otter_intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  otter_intr_ctrl_if.slave  bus
);
  localparam int IW = $clog2(NUM_SRC);
  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;
  state_t             r_state;
  logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pend;
  logic               r_intr;
  logic [IW-1:0]      r_id;
  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_clr;
  logic [IW-1:0]      w_low;
  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_elig = r_pend & bus.irq_en;
  assign w_clr  = (r_state == REQ && bus.int_taken) ? NUM_SRC'(1) << r_id : '0;
  // descending scan so the lowest eligible index is the last one written
  always_comb begin
    w_low = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (w_elig[i]) w_low = IW'(i);
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev  <= '0;
      r_pend  <= '0;
      r_state <= IDLE;
      r_intr  <= 1'b0;
      r_id    <= '0;
    end else begin
      r_sync[0] <= bus.irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
      // OR-ing edges after the clear makes a coincident new event win
      r_pend <= (r_pend & ~w_clr) | w_edge;
      case (r_state)
        IDLE:
          if (bus.mie && |w_elig) begin
            r_state <= REQ;
            r_intr  <= 1'b1;
            r_id    <= w_low;
          end
        REQ:
          if (bus.int_taken) begin
            r_state <= ACTIVE;
            r_intr  <= 1'b0;
          end else if (!bus.mie || !w_elig[r_id]) begin
            r_state <= IDLE;
            r_intr  <= 1'b0;
          end
        ACTIVE:
          if (bus.mret_exec) r_state <= IDLE;
        default: begin
          r_state <= IDLE;
          r_intr  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.intr        = r_intr;
  assign bus.irq_id      = r_id;
  assign bus.irq_pending = r_pend;
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed scoreboard bench for otter_intr_ctrl (NUM_SRC=4, SYNC_STAGES=2)
module tb_otter_intr_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  otter_intr_ctrl_if #(.NUM_SRC(4)) bus ();
  otter_intr_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    string      name;
    logic       intr;
    logic [1:0] id;
    logic       chk_id;
    logic [3:0] pend;
  } exp_t;
  exp_t q[$];
  int passed = 0;
  int total  = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string name, input logic intr, input logic [1:0] id,
                            input logic chk_id, input logic [3:0] pend);
    exp_t e;
    e.name = name; e.intr = intr; e.id = id; e.chk_id = chk_id; e.pend = pend;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (bus.intr === e.intr && bus.irq_pending === e.pend && (!e.chk_id || bus.irq_id === e.id))
        passed++;
      else
        $display("FAIL %s: got intr=%b id=%0d pend=%b, want intr=%b id=%0d%s pend=%b", e.name,
                 bus.intr, bus.irq_id, bus.irq_pending, e.intr, e.id, e.chk_id ? "" : "(any)", e.pend);
    end
  end
  initial begin
    rst_n = 1'b0;
    bus.irq_in = '0; bus.irq_en = '0; bus.mie = 1'b0; bus.int_taken = 1'b0; bus.mret_exec = 1'b0;
    tick(); tick();
    expect_out("reset", 0, 0, 1, 4'b0000);
    // 1: single pulse on source 2
    rst_n = 1'b1; bus.irq_en = 4'hF; bus.mie = 1'b1; bus.irq_in = 4'b0100;
    tick(); bus.irq_in = '0;
    tick(); expect_out("t1_sync", 0, 0, 1, 4'b0000);
    tick(); expect_out("t1_pend", 0, 0, 1, 4'b0100);
    tick(); expect_out("t1_req", 1, 2, 1, 4'b0100);
    bus.int_taken = 1'b1;
    tick(); bus.int_taken = 1'b0; expect_out("t1_taken", 0, 2, 1, 4'b0000);
    bus.mret_exec = 1'b1;
    tick(); bus.mret_exec = 1'b0; expect_out("t1_mret", 0, 2, 1, 4'b0000);
    // 2: simultaneous edges, lowest index first, then the other after mret
    bus.irq_in = 4'b1010;
    tick(); bus.irq_in = '0;
    tick(); tick(); expect_out("t2_pend", 0, 2, 1, 4'b1010);
    tick(); expect_out("t2_req1", 1, 1, 1, 4'b1010);
    bus.int_taken = 1'b1;
    tick(); bus.int_taken = 1'b0; expect_out("t2_taken", 0, 1, 1, 4'b1000);
    tick(); expect_out("t2_active", 0, 1, 1, 4'b1000);
    bus.mret_exec = 1'b1;
    tick(); bus.mret_exec = 1'b0; expect_out("t2_mret_idle", 0, 1, 1, 4'b1000);
    tick(); expect_out("t2_req3", 1, 3, 1, 4'b1000);
    bus.int_taken = 1'b1;
    tick(); bus.int_taken = 1'b0; expect_out("t2_taken3", 0, 3, 1, 4'b0000);
    bus.mret_exec = 1'b1;
    tick(); bus.mret_exec = 1'b0;
    // 3: MIE gating and withdraw on enable drop
    bus.mie = 1'b0; bus.irq_in = 4'b0001;
    tick(); bus.irq_in = '0;
    tick(); tick(); expect_out("t3_pend", 0, 3, 1, 4'b0001);
    tick(); expect_out("t3_mie0", 0, 3, 1, 4'b0001);
    bus.mie = 1'b1;
    tick(); expect_out("t3_mie1", 1, 0, 1, 4'b0001);
    bus.irq_en = 4'h0;
    tick(); expect_out("t3_withdraw", 0, 0, 1, 4'b0001);
    // 4: new edge on source 0 lands in the INT_TAKEN cycle
    bus.irq_en = 4'hF; bus.irq_in = 4'b0001;
    tick(); bus.irq_in = '0; expect_out("t4_req", 1, 0, 1, 4'b0001);
    tick(); bus.int_taken = 1'b1;
    tick(); bus.int_taken = 1'b0; expect_out("t4_setwins", 0, 0, 1, 4'b0001);
    bus.mret_exec = 1'b1;
    tick(); bus.mret_exec = 1'b0; expect_out("t4_idle", 0, 0, 1, 4'b0001);
    tick(); expect_out("t4_rereq", 1, 0, 1, 4'b0001);
    bus.int_taken = 1'b1;
    tick(); bus.int_taken = 1'b0; expect_out("t4_clr", 0, 0, 1, 4'b0000);
    // 5: reset while ACTIVE with pending events
    bus.irq_in = 4'b0110;
    tick(); bus.irq_in = '0;
    tick(); tick(); expect_out("t5_pend", 0, 0, 1, 4'b0110);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; expect_out("t5_rst", 0, 0, 1, 4'b0000);
    bus.mret_exec = 1'b1;
    tick(); bus.mret_exec = 1'b0; expect_out("t5_mret", 0, 0, 1, 4'b0000);
    tick(); expect_out("t5_quiet", 0, 0, 1, 4'b0000);
    // 6: a held level produces exactly one event
    bus.irq_in = 4'b0001;
    tick(); tick(); tick(); expect_out("t6_pend", 0, 0, 1, 4'b0001);
    tick(); expect_out("t6_req", 1, 0, 1, 4'b0001);
    bus.int_taken = 1'b1;
    tick(); bus.int_taken = 1'b0; expect_out("t6_taken", 0, 0, 1, 4'b0000);
    bus.mret_exec = 1'b1;
    tick(); bus.mret_exec = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick(); expect_out("t6_held", 0, 0, 1, 4'b0000);
    end
    bus.irq_in = '0;
    for (int i = 0; i < 4; i++) begin
      tick(); expect_out("t6_low", 0, 0, 1, 4'b0000);
    end
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
